sdram_cmd_arbiter: RTL

- Sits between the APB-facing request logic and the SDRAM command sequencer inside sdram_controller.
- Arbitrates between two requesters (port 0 = APB host path, port 1 = auxiliary/DMA path) for the single SDRAM command slot.
- Owns the periodic auto-refresh timer. Injects refresh commands, postponing them while traffic is present up to a hard limit.
- Issues one command at a time over a valid/ready handshake.

---
 rtl/sdram_cmd_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sdram_cmd_arbiter.sv
// Command-slot arbiter for the SDRAM controller: round-robin between two
// requesters plus an auto-refresh engine that postpones refreshes under load.
module sdram_cmd_arbiter #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int MAX_POSTPONE     = 4,
    parameter int ADDR_W           = 22,
    parameter int DATA_W           = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              init_done,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic [1:0]        cmd_src,
    output logic [2:0]        ref_pending,
    output logic              ref_overrun
);
    localparam int             TW     = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(REFRESH_INTERVAL - 1);
    localparam logic [2:0]     P_MAX  = 3'(MAX_POSTPONE);

    typedef enum logic {S_IDLE, S_ISSUE} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              rr_q, rr_d;
    logic [1:0]        type_q, type_d;
    logic [1:0]        src_q, src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              tick, ref_acc, urgent, idle_ok, g0, g1, do_ref;

    // Refresh timer and pending/overrun bookkeeping
    assign tick    = init_done && (timer_q == T_LAST);
    assign ref_acc = cmd_valid && cmd_ready && (type_q == 2'b10);

    always_comb begin
        timer_d = timer_q;
        if (init_done) timer_d = tick ? '0 : timer_q + 1'b1;
    end

    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (tick && !ref_acc) begin
            if (pend_q >= P_MAX) ovr_d = 1'b1;
            else                 pend_d = pend_q + 1'b1;
        end else if (ref_acc && !tick) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Decision terms; rr_q names the port preferred when both request
    assign idle_ok = (state_q == S_IDLE) && init_done && !preset;
    assign urgent  = (pend_q >= P_MAX);
    assign g0      = idle_ok && !urgent && r0_req && (!r1_req || !rr_q);
    assign g1      = idle_ok && !urgent && r1_req && (!r0_req || rr_q);
    assign do_ref  = idle_ok && (urgent || (!r0_req && !r1_req && pend_q != 3'd0));

    // FSM: state register
    always_ff @(posedge pclk) begin
        if (preset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (g0 || g1 || do_ref) state_d = S_ISSUE;
            S_ISSUE: if (cmd_ready)          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_valid = (state_q == S_ISSUE);
        r0_gnt    = g0;
        r1_gnt    = g1;
    end

    // Command latch; wdata is forced to 0 for reads and refreshes
    always_comb begin
        type_d  = type_q;
        src_d   = src_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rr_d    = rr_q;
        if (g0) begin
            type_d  = {1'b0, r0_write};
            src_d   = 2'b00;
            addr_d  = r0_addr;
            wdata_d = r0_write ? r0_wdata : '0;
            rr_d    = 1'b1;
        end else if (g1) begin
            type_d  = {1'b0, r1_write};
            src_d   = 2'b01;
            addr_d  = r1_addr;
            wdata_d = r1_write ? r1_wdata : '0;
            rr_d    = 1'b0;
        end else if (do_ref) begin
            type_d  = 2'b10;
            src_d   = 2'b10;
            addr_d  = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            timer_q <= '0;
            pend_q  <= '0;
            ovr_q   <= 1'b0;
            rr_q    <= 1'b0;
            type_q  <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            rr_q    <= rr_d;
            type_q  <= type_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign cmd_type    = type_q;
    assign cmd_src     = src_q;
    assign cmd_addr    = addr_q;
    assign cmd_wdata   = wdata_q;
    assign ref_pending = pend_q;
    assign ref_overrun = ovr_q;

endmodule
